// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg
// Shared definitions for the data-memory bus bridge:
//   Xlen        data/address width
//   len_e       access-size encoding used on i_len_r / i_len_w
//   state_e     bridge FSM state encoding
//   strb_base() byte-enable pattern for a size, before lane shifting
//   is_misaligned() size/offset legality check
package dmem_bus_bridge_pkg;

  localparam int unsigned Xlen = 32;
  localparam int unsigned StrbW = Xlen / 8;

  typedef enum logic [1:0] {
    LenB       = 2'd0,
    LenH       = 2'd1,
    LenW       = 2'd2,
    LenIllegal = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWrReq  = 2'd1,
    StRdReq  = 2'd2,
    StRdWait = 2'd3
  } state_e;

  // Byte enables for lane 0; the caller shifts them to the addressed lane.
  function automatic logic [StrbW-1:0] strb_base(len_e len);
    logic [StrbW-1:0] strb;
    case (len)
      LenB:    strb = 4'b0001;
      LenH:    strb = 4'b0011;
      LenW:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Halves need an even address, words a word-aligned one; size 3 is never legal.
  function automatic logic is_misaligned(len_e len, logic [1:0] off);
    logic mis;
    case (len)
      LenB:    mis = 1'b0;
      LenH:    mis = off[0];
      LenW:    mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// dmem_bus_bridge_if
// Word-aligned request/grant/rvalid data bus.
//   req    request valid, held until gnt
//   we     1 = write
//   addr   word address, bits [1:0] always zero
//   wdata  lane-aligned store data
//   wstrb  byte-lane enables
//   gnt    request accepted this cycle
//   rvalid read data valid (at least one cycle after gnt)
//   rdata  read word
// Modports: master (the bridge), slave (the memory / bus model).
interface dmem_bus_bridge_if;
  import dmem_bus_bridge_pkg::*;

  logic             req;
  logic             we;
  logic [Xlen-1:0]  addr;
  logic [Xlen-1:0]  wdata;
  logic [StrbW-1:0] wstrb;
  logic             gnt;
  logic             rvalid;
  logic [Xlen-1:0]  rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output wstrb,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  wstrb,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
// Combinational byte-lane handling for the bridge.
//   read_en_i / write_en_i   which accesses are present this cycle
//   len_r_i / off_r_i        load size and byte offset
//   len_w_i / off_w_i        store size and byte offset
//   data_w_i                 right-justified store data
//   rd_off_i                 byte offset of the outstanding load
//   rdata_i                  raw bus read word
//   wdata_o / wstrb_o        lane-aligned store data and byte enables
//   rdata_o                  load data shifted down to bit 0, zero-filled
//   misaligned_o             any present access is illegal
module dmem_lane_align
  import dmem_bus_bridge_pkg::*;
(
  input  logic             read_en_i,
  input  logic [1:0]       len_r_i,
  input  logic [1:0]       off_r_i,
  input  logic             write_en_i,
  input  logic [1:0]       len_w_i,
  input  logic [1:0]       off_w_i,
  input  logic [Xlen-1:0]  data_w_i,
  input  logic [1:0]       rd_off_i,
  input  logic [Xlen-1:0]  rdata_i,
  output logic [Xlen-1:0]  wdata_o,
  output logic [StrbW-1:0] wstrb_o,
  output logic [Xlen-1:0]  rdata_o,
  output logic             misaligned_o
);

  logic rd_mis;
  logic wr_mis;

  always_comb begin
    wdata_o = data_w_i << {off_w_i, 3'b000};
    wstrb_o = strb_base(len_e'(len_w_i)) << off_w_i;
    // Upper bytes are zero-filled; sign/zero extension happens downstream.
    rdata_o = rdata_i >> {rd_off_i, 3'b000};

    rd_mis       = read_en_i & is_misaligned(len_e'(len_r_i), off_r_i);
    wr_mis       = write_en_i & is_misaligned(len_e'(len_w_i), off_w_i);
    misaligned_o = rd_mis | wr_mis;
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
// Turns the memory-access stage's data-memory port into word-aligned
// request/grant/rvalid bus transactions, stalling the pipeline while one is
// outstanding. A combined load+store issues the store first, then the load.
//   clk, rst            clock, synchronous active-high reset
//   i_read_en/i_addr_r/i_len_r               load request
//   i_write_en/i_addr_w/i_data_w/i_len_w     store request
//   o_data_r            registered load data, right-justified
//   o_stall             freeze the pipeline (combinational)
//   o_misaligned        one-cycle pulse: access rejected
//   bus_io              data bus, master side (all outputs registered)
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_read_en,
  input  logic [Xlen-1:0] i_addr_r,
  input  logic [1:0]      i_len_r,
  input  logic            i_write_en,
  input  logic [Xlen-1:0] i_addr_w,
  input  logic [Xlen-1:0] i_data_w,
  input  logic [1:0]      i_len_w,
  output logic [Xlen-1:0] o_data_r,
  output logic            o_stall,
  output logic            o_misaligned,
  dmem_bus_bridge_if.master bus_io
);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [Xlen-1:0]  addr_q, addr_d;
  logic [Xlen-1:0]  wdata_q, wdata_d;
  logic [StrbW-1:0] wstrb_q, wstrb_d;
  logic [Xlen-1:0]  data_r_q, data_r_d;
  logic             misaligned_q, misaligned_d;
  logic [Xlen-1:0]  addr_r_q, addr_r_d;
  logic             pend_rd_q, pend_rd_d;

  logic             request;
  logic             lane_mis;
  logic [Xlen-1:0]  lane_wdata;
  logic [StrbW-1:0] lane_wstrb;
  logic [Xlen-1:0]  lane_rdata;

  dmem_lane_align u_lane_align (
    .read_en_i    (i_read_en),
    .len_r_i      (i_len_r),
    .off_r_i      (i_addr_r[1:0]),
    .write_en_i   (i_write_en),
    .len_w_i      (i_len_w),
    .off_w_i      (i_addr_w[1:0]),
    .data_w_i     (i_data_w),
    .rd_off_i     (addr_r_q[1:0]),
    .rdata_i      (bus_io.rdata),
    .wdata_o      (lane_wdata),
    .wstrb_o      (lane_wstrb),
    .rdata_o      (lane_rdata),
    .misaligned_o (lane_mis)
  );

  assign request = i_read_en | i_write_en;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    data_r_d     = data_r_q;
    misaligned_d = 1'b0;
    addr_r_d     = addr_r_q;
    pend_rd_d    = pend_rd_q;
    o_stall      = 1'b0;

    case (state_q)
      StIdle: begin
        if (request) begin
          if (lane_mis) begin
            // Reject both accesses; the pipeline is not held.
            misaligned_d = 1'b1;
            if (i_read_en) data_r_d = '0;
          end else begin
            o_stall   = 1'b1;
            addr_r_d  = i_addr_r;
            pend_rd_d = i_read_en;
            req_d     = 1'b1;
            if (i_write_en) begin
              state_d = StWrReq;
              we_d    = 1'b1;
              addr_d  = {i_addr_w[Xlen-1:2], 2'b00};
              wdata_d = lane_wdata;
              wstrb_d = lane_wstrb;
            end else begin
              state_d = StRdReq;
              we_d    = 1'b0;
              addr_d  = {i_addr_r[Xlen-1:2], 2'b00};
              wstrb_d = '0;
            end
          end
        end
      end

      StWrReq: begin
        // A granted store with no load behind it completes this cycle.
        o_stall = !(bus_io.gnt && !pend_rd_q);
        if (bus_io.gnt) begin
          we_d = 1'b0;
          if (pend_rd_q) begin
            state_d = StRdReq;
            addr_d  = {addr_r_q[Xlen-1:2], 2'b00};
            wstrb_d = '0;
          end else begin
            state_d = StIdle;
            req_d   = 1'b0;
          end
        end
      end

      StRdReq: begin
        o_stall = 1'b1;
        if (bus_io.gnt) begin
          state_d = StRdWait;
          req_d   = 1'b0;
        end
      end

      StRdWait: begin
        o_stall = !bus_io.rvalid;
        if (bus_io.rvalid) begin
          data_r_d = lane_rdata;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      data_r_q     <= '0;
      misaligned_q <= 1'b0;
      addr_r_q     <= '0;
      pend_rd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      data_r_q     <= data_r_d;
      misaligned_q <= misaligned_d;
      addr_r_q     <= addr_r_d;
      pend_rd_q    <= pend_rd_d;
    end
  end

  assign bus_io.req   = req_q;
  assign bus_io.we    = we_q;
  assign bus_io.addr  = addr_q;
  assign bus_io.wdata = wdata_q;
  assign bus_io.wstrb = wstrb_q;
  assign o_data_r     = data_r_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge. Inputs change 1 time unit after the
// rising edge; outputs are checked 1 time unit later, well before the next edge.
module tb_dmem_bus_bridge;

  logic        clk;
  logic        rst;
  logic        read_en;
  logic [31:0] addr_r;
  logic [1:0]  len_r;
  logic        write_en;
  logic [31:0] addr_w;
  logic [31:0] data_w;
  logic [1:0]  len_w;
  logic [31:0] data_r;
  logic        stall;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  dmem_bus_bridge_if bus_if ();

  dmem_bus_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .i_read_en    (read_en),
    .i_addr_r     (addr_r),
    .i_len_r      (len_r),
    .i_write_en   (write_en),
    .i_addr_w     (addr_w),
    .i_data_w     (data_w),
    .i_len_w      (len_w),
    .o_data_r     (data_r),
    .o_stall      (stall),
    .o_misaligned (misaligned),
    .bus_io       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    read_en       = 1'b0;
    write_en      = 1'b0;
    bus_if.gnt    = 1'b0;
    bus_if.rvalid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    read_en       = 1'b0;
    addr_r        = '0;
    len_r         = 2'd0;
    write_en      = 1'b0;
    addr_w        = '0;
    data_w        = '0;
    len_w         = 2'd0;
    bus_if.gnt    = 1'b0;
    bus_if.rvalid = 1'b0;
    bus_if.rdata  = '0;

    next_cycle();
    next_cycle();
    rst = 1'b0;
    settle();
    check_eq("rst_req", {31'd0, bus_if.req}, 32'd0);
    check_eq("rst_we", {31'd0, bus_if.we}, 32'd0);
    check_eq("rst_addr", bus_if.addr, 32'd0);
    check_eq("rst_wdata", bus_if.wdata, 32'd0);
    check_eq("rst_wstrb", {28'd0, bus_if.wstrb}, 32'd0);
    check_eq("rst_data_r", data_r, 32'd0);
    check_eq("rst_mis", {31'd0, misaligned}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);

    // Stray grant while idle must not start anything.
    bus_if.gnt = 1'b1;
    next_cycle();
    bus_if.gnt = 1'b0;
    settle();
    check_eq("idle_gnt_req", {31'd0, bus_if.req}, 32'd0);

    // Store byte 0xAB to 0x1003, immediate grant.
    write_en = 1'b1; addr_w = 32'h1003; data_w = 32'h0000_00AB; len_w = 2'd0;
    settle();
    check_eq("sb_acc_stall", {31'd0, stall}, 32'd1);
    check_eq("sb_acc_req", {31'd0, bus_if.req}, 32'd0);
    next_cycle();
    bus_if.gnt = 1'b1;
    settle();
    check_eq("sb_req", {31'd0, bus_if.req}, 32'd1);
    check_eq("sb_we", {31'd0, bus_if.we}, 32'd1);
    check_eq("sb_addr", bus_if.addr, 32'h0000_1000);
    check_eq("sb_wdata", bus_if.wdata, 32'hAB00_0000);
    check_eq("sb_wstrb", {28'd0, bus_if.wstrb}, 32'b1000);
    check_eq("sb_done_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check_eq("sb_after_req", {31'd0, bus_if.req}, 32'd0);
    check_eq("sb_after_stall", {31'd0, stall}, 32'd0);

    // Store half 0x1234 to 0x102.
    write_en = 1'b1; addr_w = 32'h0000_0102; data_w = 32'h0000_1234; len_w = 2'd1;
    next_cycle();
    bus_if.gnt = 1'b1;
    settle();
    check_eq("sh_wdata", bus_if.wdata, 32'h1234_0000);
    check_eq("sh_wstrb", {28'd0, bus_if.wstrb}, 32'b1100);
    check_eq("sh_addr", bus_if.addr, 32'h0000_0100);
    next_cycle();
    idle_inputs();

    // Load half from 0x2002, zero-wait bus.
    read_en = 1'b1; addr_r = 32'h2002; len_r = 2'd1;
    settle();
    check_eq("lh_acc_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    bus_if.gnt = 1'b1;
    settle();
    check_eq("lh_req", {31'd0, bus_if.req}, 32'd1);
    check_eq("lh_we", {31'd0, bus_if.we}, 32'd0);
    check_eq("lh_addr", bus_if.addr, 32'h0000_2000);
    check_eq("lh_req_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h8001_1234;
    settle();
    check_eq("lh_wait_req", {31'd0, bus_if.req}, 32'd0);
    check_eq("lh_done_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check_eq("lh_data", data_r, 32'h0000_8001);

    // Load byte from offset 1.
    read_en = 1'b1; addr_r = 32'h0000_0041; len_r = 2'd0;
    next_cycle();
    bus_if.gnt = 1'b1;
    next_cycle();
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h1122_3344;
    next_cycle();
    idle_inputs();
    settle();
    check_eq("lb_data", data_r, 32'h0011_2233);

    // Load word, grant withheld 3 cycles, rvalid 2 cycles late.
    read_en = 1'b1; addr_r = 32'h0000_3000; len_r = 2'd2;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("lw_hold_req%0d", i), {31'd0, bus_if.req}, 32'd1);
      check_eq($sformatf("lw_hold_addr%0d", i), bus_if.addr, 32'h0000_3000);
      check_eq($sformatf("lw_hold_stall%0d", i), {31'd0, stall}, 32'd1);
      next_cycle();
    end
    bus_if.gnt = 1'b1;
    settle();
    check_eq("lw_gnt_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    bus_if.gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq($sformatf("lw_wait_stall%0d", i), {31'd0, stall}, 32'd1);
      check_eq($sformatf("lw_wait_req%0d", i), {31'd0, bus_if.req}, 32'd0);
      next_cycle();
    end
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'hCAFE_F00D;
    settle();
    check_eq("lw_done_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check_eq("lw_data", data_r, 32'hCAFE_F00D);

    // Store word 0xDEADBEEF @0x10 together with load word @0x20.
    write_en = 1'b1; addr_w = 32'h10; data_w = 32'hDEAD_BEEF; len_w = 2'd2;
    read_en  = 1'b1; addr_r = 32'h20; len_r = 2'd2;
    settle();
    check_eq("rw_acc_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    bus_if.gnt = 1'b1;
    settle();
    check_eq("rw_wr_we", {31'd0, bus_if.we}, 32'd1);
    check_eq("rw_wr_addr", bus_if.addr, 32'h0000_0010);
    check_eq("rw_wr_wdata", bus_if.wdata, 32'hDEAD_BEEF);
    check_eq("rw_wr_wstrb", {28'd0, bus_if.wstrb}, 32'hF);
    check_eq("rw_wr_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    settle();
    check_eq("rw_rd_req", {31'd0, bus_if.req}, 32'd1);
    check_eq("rw_rd_we", {31'd0, bus_if.we}, 32'd0);
    check_eq("rw_rd_addr", bus_if.addr, 32'h0000_0020);
    check_eq("rw_rd_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h1234_5678;
    settle();
    check_eq("rw_done_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check_eq("rw_data", data_r, 32'h1234_5678);

    // Misaligned load word @0x5.
    read_en = 1'b1; addr_r = 32'h5; len_r = 2'd2;
    settle();
    check_eq("mis_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check_eq("mis_pulse", {31'd0, misaligned}, 32'd1);
    check_eq("mis_req", {31'd0, bus_if.req}, 32'd0);
    check_eq("mis_data", data_r, 32'd0);
    next_cycle();
    check_eq("mis_pulse_end", {31'd0, misaligned}, 32'd0);

    // Illegal store size 3 with an aligned load: both rejected.
    write_en = 1'b1; addr_w = 32'h40; len_w = 2'd3;
    read_en  = 1'b1; addr_r = 32'h44; len_r = 2'd2;
    settle();
    check_eq("len3_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check_eq("len3_pulse", {31'd0, misaligned}, 32'd1);
    check_eq("len3_req", {31'd0, bus_if.req}, 32'd0);

    // Reset while waiting for read data, then a stray rvalid.
    read_en = 1'b1; addr_r = 32'h80; len_r = 2'd2;
    next_cycle();
    bus_if.gnt = 1'b1;
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
    check_eq("rst_mid_req", {31'd0, bus_if.req}, 32'd0);
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'hFFFF_FFFF;
    settle();
    check_eq("rst_mid_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    bus_if.rvalid = 1'b0;
    settle();
    check_eq("rst_mid_data", data_r, 32'd0);
    check_eq("rst_mid_stall2", {31'd0, stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
